// File: rtl/myfilter_pkg.sv
// Shared constants and types for the I2C slave controller.
package myfilter_pkg;

  // 7-bit slave address this block answers to
  localparam logic [6:0]  I2C_ADDRESS        = 7'h3A;
  // SCL-low cycles tolerated while a transfer is in progress
  localparam logic [15:0] I2C_TIMEOUT_CYCLES = 16'd200;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } i2c_ctl_state_t;

endpackage

// File: rtl/i2c_ctl_bus_det.sv
// I2C bus event detector: SCL edges plus START/STOP conditions.
// START/STOP need SCL high in both the registered and the current sample,
// so they can never coincide with an SCL edge.
module i2c_bus_det (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_q;
  logic sda_q;

  // previous bus sample; resets to the idle-high level so reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_in;
      sda_q <= sda_in;
    end
  end

  assign scl_rise  =  scl_in & ~scl_q;
  assign scl_fall  = ~scl_in &  scl_q;
  assign start_det =  scl_in &  scl_q &  sda_q & ~sda_in;
  assign stop_det  =  scl_in &  scl_q & ~sda_q &  sda_in;

endmodule

// File: rtl/i2c_ctl.sv
// I2C write-only slave controller FSM.
// Optional SCL-low timeout enabled by defining I2C_CTL_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W bit
// ADDR_ACK | driving ACK for our address (write)
// DATA     | shifting in a data byte
// DATA_ACK | driving ACK for a received data byte
// IGNORE   | not addressed (or read), wait for START/STOP
module i2c_ctl
  import myfilter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  input  logic addrok_in,
  input  logic srg_bit_in,
  output logic clr_out,
  output logic next_out,
  output logic sda_bit_out,
  output logic sda_oe_out,
  output logic byte_valid_out,
  output logic busy_out,
  output logic timeout_out
);

  i2c_ctl_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic clr_nxt, next_nxt, bit_nxt, oe_nxt, bv_nxt;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic ack_addr;
  logic to_hit;

  i2c_bus_det u_bus_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign ack_addr = addrok_in & ~srg_bit_in;
  assign busy_out = (state != IDLE);

`ifdef I2C_CTL_TIMEOUT_EN
  logic [15:0] to_cnt;

  // fires on the last tolerated SCL-low cycle of an active transfer
  assign to_hit = (state != IDLE) && !scl_in && (to_cnt == 16'd1);

  // down-counter of SCL-low cycles, reloaded whenever SCL is high or the bus is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= I2C_TIMEOUT_CYCLES;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= to_hit;
      if (scl_in || (state == IDLE) || to_hit) to_cnt <= I2C_TIMEOUT_CYCLES;
      else                                     to_cnt <= to_cnt - 16'd1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_out = 1'b0;
`endif

  // state, bit counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      clr_out        <= 1'b0;
      next_out       <= 1'b0;
      sda_bit_out    <= 1'b0;
      sda_oe_out     <= 1'b0;
      byte_valid_out <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      clr_out        <= clr_nxt;
      next_out       <= next_nxt;
      sda_bit_out    <= bit_nxt;
      sda_oe_out     <= oe_nxt;
      byte_valid_out <= bv_nxt;
    end
  end

  // next state and bit counter; START beats STOP/timeout beats normal sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (start_det) begin
      state_nxt = ADDR;
      cnt_nxt   = 4'd0;
    end else if (stop_det || to_hit) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise) begin
            if (cnt != 4'd9) cnt_nxt = cnt + 4'd1;
          end else if (scl_fall && (cnt == 4'd8)) begin
            if (state == DATA) state_nxt = DATA_ACK;
            else               state_nxt = ack_addr ? ADDR_ACK : IGNORE;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            state_nxt = DATA;
            cnt_nxt   = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // next values of the registered outputs
  always_comb begin
    clr_nxt  = 1'b0;
    next_nxt = 1'b0;
    bit_nxt  = 1'b0;
    bv_nxt   = 1'b0;
    oe_nxt   = sda_oe_out;
    if (start_det) begin
      clr_nxt = 1'b1;
      oe_nxt  = 1'b0;
    end else if (stop_det || to_hit) begin
      oe_nxt = 1'b0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise) begin
            next_nxt = 1'b1;
            bit_nxt  = sda_in;
          end else if (scl_fall && (cnt == 4'd8)) begin
            if (state == DATA) begin
              bv_nxt = 1'b1;
              oe_nxt = 1'b1;
            end else begin
              oe_nxt = ack_addr;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            oe_nxt  = 1'b0;
            clr_nxt = 1'b1;
          end
        end
        IGNORE:  oe_nxt = 1'b0;
        default: oe_nxt = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_ctl.sv
// Self-checking bench for i2c_ctl: directed bus sequences plus randomized
// write transactions. Expected behaviour is derived per transaction from
// whether the slave is addressed for a write.
module tb_i2c_ctl;
  import myfilter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic addrok_in = 1'b0;
  logic srg_bit_in = 1'b0;
  logic clr_out, next_out, sda_bit_out, sda_oe_out, byte_valid_out, busy_out, timeout_out;

  int checks = 0;
  int errors = 0;

  i2c_ctl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scl_in         (scl_in),
    .sda_in         (sda_in),
    .addrok_in      (addrok_in),
    .srg_bit_in     (srg_bit_in),
    .clr_out        (clr_out),
    .next_out       (next_out),
    .sda_bit_out    (sda_bit_out),
    .sda_oe_out     (sda_oe_out),
    .byte_valid_out (byte_valid_out),
    .busy_out       (busy_out),
    .timeout_out    (timeout_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // change the bus, let the detection edge pass, return sampled mid-cycle
  task automatic drive(input logic s, input logic d);
    @(negedge clk);
    scl_in = s;
    sda_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input string tag);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    chk({tag, "_clr"}, clr_out, 1'b1);
    chk({tag, "_busy"}, busy_out, 1'b1);
    chk({tag, "_oe"}, sda_oe_out, 1'b0);
    drive(1'b0, 1'b0);
    chk({tag, "_clr_pulse"}, clr_out, 1'b0);
  endtask

  task automatic do_stop(input string tag);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    chk({tag, "_busy"}, busy_out, 1'b0);
    chk({tag, "_oe"}, sda_oe_out, 1'b0);
    chk({tag, "_bv"}, byte_valid_out, 1'b0);
    chk({tag, "_to"}, timeout_out, 1'b0);
  endtask

  // eight bits MSB first; 'shifting' says whether next_out pulses are expected
  task automatic send_byte(input logic [7:0] b, input bit shifting, input string tag);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b0, b[i]);
      drive(1'b1, b[i]);
      chk({tag, "_next"}, next_out, shifting);
      if (shifting) chk({tag, "_bit"}, sda_bit_out, b[i]);
      chk({tag, "_oe_bit"}, sda_oe_out, 1'b0);
      drive(1'b0, b[i]);
      if (i > 0) chk({tag, "_bv_early"}, byte_valid_out, 1'b0);
    end
  endtask

  // ninth clock: bus carries ACK (0) if the slave drives, else NACK (1)
  task automatic ack_clock(input bit acked, input string tag);
    drive(1'b0, !acked);
    drive(1'b1, !acked);
    chk({tag, "_ack_next"}, next_out, 1'b0);
    chk({tag, "_ack_oe"}, sda_oe_out, acked);
    drive(1'b0, !acked);
    chk({tag, "_ack_clr"}, clr_out, acked);
    chk({tag, "_ack_release"}, sda_oe_out, 1'b0);
  endtask

  task automatic send_addr(input bit ok, input bit rw, input string tag);
    bit acked;
    acked = ok && !rw;
    addrok_in  = ok;
    srg_bit_in = rw;
    send_byte({I2C_ADDRESS, rw}, 1'b1, tag);
    chk({tag, "_addr_oe"}, sda_oe_out, acked);
    chk({tag, "_addr_bv"}, byte_valid_out, 1'b0);
    chk({tag, "_addr_busy"}, busy_out, 1'b1);
    ack_clock(acked, tag);
  endtask

  task automatic send_data(input logic [7:0] d, input bit acked, input string tag);
    send_byte(d, acked, tag);
    chk({tag, "_bv"}, byte_valid_out, acked);
    chk({tag, "_data_oe"}, sda_oe_out, acked);
    ack_clock(acked, tag);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_oe", sda_oe_out, 1'b0);
    chk("rst_clr", clr_out, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy_out, 1'b0);
    chk("idle_next", next_out, 1'b0);
    chk("idle_clr", clr_out, 1'b0);
    chk("idle_bv", byte_valid_out, 1'b0);
    chk("idle_oe", sda_oe_out, 1'b0);
    chk("idle_to", timeout_out, 1'b0);

    // addressed write with data 8'hA5
    do_start("a5_start");
    send_addr(1'b1, 1'b0, "a5_addr");
    send_data(8'hA5, 1'b1, "a5_data");
    do_stop("a5_stop");

    // address mismatch and read both ignored
    do_start("mis_start");
    send_addr(1'b0, 1'b0, "mis_addr");
    send_data(8'h3C, 1'b0, "mis_data");
    chk("mis_busy", busy_out, 1'b1);
    do_stop("mis_stop");
    do_start("rd_start");
    send_addr(1'b1, 1'b1, "rd_addr");
    send_data(8'hFF, 1'b0, "rd_data");
    do_stop("rd_stop");

    // repeated START after four data bits discards the partial byte
    do_start("rs_start");
    send_addr(1'b1, 1'b0, "rs_addr");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      chk("rs_bit_next", next_out, 1'b1);
      drive(1'b0, 1'b0);
      chk("rs_bit_bv", byte_valid_out, 1'b0);
    end
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    chk("rs_clr", clr_out, 1'b1);
    chk("rs_bv", byte_valid_out, 1'b0);
    chk("rs_oe", sda_oe_out, 1'b0);
    chk("rs_busy", busy_out, 1'b1);
    drive(1'b0, 1'b0);
    send_addr(1'b1, 1'b0, "rs_addr2");
    send_data(8'h5A, 1'b1, "rs_data2");
    do_stop("rs_stop");

    // reset during the address ACK releases SDA; bits without START are ignored
    do_start("mr_start");
    addrok_in  = 1'b1;
    srg_bit_in = 1'b0;
    send_byte({I2C_ADDRESS, 1'b0}, 1'b1, "mr_addr");
    chk("mr_ack_oe", sda_oe_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_oe", sda_oe_out, 1'b0);
    chk("mr_rst_busy", busy_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    chk("mr_after_busy", busy_out, 1'b0);
    send_byte(8'hC3, 1'b0, "mr_nostart");
    chk("mr_nostart_busy", busy_out, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);

    // randomized transactions
    for (int t = 0; t < 6; t++) begin
      bit ok, rw, acked;
      int nbytes;
      logic [7:0] d;
      ok     = (t < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      rw     = (t < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      acked  = ok && !rw;
      nbytes = int'($urandom_range(1, 3));
      do_start("rnd_start");
      send_addr(ok, rw, "rnd_addr");
      for (int n = 0; n < nbytes; n++) begin
        d = 8'($urandom);
        send_data(d, acked, "rnd_data");
      end
      do_stop("rnd_stop");
    end

`ifdef I2C_CTL_TIMEOUT_EN
    // SCL held low during the data ACK
    begin
      bit seen;
      seen = 1'b0;
      do_start("to_start");
      send_addr(1'b1, 1'b0, "to_addr");
      send_byte(8'h96, 1'b1, "to_data");
      chk("to_ack_oe", sda_oe_out, 1'b1);
      for (int k = 0; k < int'(I2C_TIMEOUT_CYCLES) + 20; k++) begin
        @(negedge clk);
        if (timeout_out === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      chk("to_pulse", seen, 1'b1);
      chk("to_oe", sda_oe_out, 1'b0);
      chk("to_busy", busy_out, 1'b0);
      @(negedge clk);
      chk("to_pulse_width", timeout_out, 1'b0);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_ctl.md
I2C_CTL -- requirements
Module: i2c_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 scl_in  in  1  I2C SCL, already synchronized to clk.
REQ-005 sda_in  in  1  I2C SDA, already synchronized to clk.
REQ-006 addrok_in  in  1  shift-register flag: srg_r[7:1] equals I2C_ADDRESS.
REQ-007 srg_bit_in  in  1  shift-register LSB (srg_r[0], the R/W bit after an address byte).
REQ-008 clr_out  out  1  one-cycle pulse that clears the shift register.
REQ-009 next_out  out  1  one-cycle pulse that shifts sda_bit_out into the shift register.
REQ-010 sda_bit_out  out  1  bit to shift; valid while next_out=1.
REQ-011 sda_oe_out  out  1  1 = pull SDA low (ACK).
REQ-012 byte_valid_out  out  1  one-cycle pulse: received data byte held in the shift register.
REQ-013 busy_out  out  1  1 whenever state is not IDLE.
REQ-014 timeout_out  out  1  one-cycle pulse on SCL-low timeout; constant 0 without I2C_CTL_TIMEOUT_EN.

Function
REQ-015 The block SHALL register scl_in/sda_in once and detect: scl rise, scl fall, START (sda fall while scl high), STOP (sda rise while scl high).
REQ-016 All outputs SHALL be registered; each response SHALL appear 1 cycle after the detection cycle.
REQ-017 States SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE, plus a 4-bit bit counter (0..9).
REQ-018 IDLE: on START -> ADDR, clr_out=1, counter=0.
REQ-019 ADDR/DATA: each scl rise -> next_out=1, sda_bit_out=sampled sda, counter+1.
REQ-020 ADDR: on scl fall with counter=8 -> ADDR_ACK with sda_oe_out=1 if addrok_in=1 and srg_bit_in=0 (write); otherwise -> IGNORE with sda_oe_out=0. Reads are NACKed.
REQ-021 ADDR_ACK: on next scl fall -> sda_oe_out=0, clr_out=1, counter=0, -> DATA.
REQ-022 DATA: on scl fall with counter=8 -> byte_valid_out=1, sda_oe_out=1, -> DATA_ACK.
REQ-023 DATA_ACK: on next scl fall -> sda_oe_out=0, clr_out=1, counter=0, -> DATA.
REQ-024 IGNORE: sda_oe_out=0, no next_out/clr_out pulses; leave only on START or STOP.
REQ-025 Repeated START in any state SHALL take priority: -> ADDR, clr_out=1, counter=0, sda_oe_out=0.
REQ-026 STOP in any state SHALL give IDLE and sda_oe_out=0; a byte with fewer than 8 bits SHALL be discarded with no byte_valid_out.
REQ-027 START and scl edges SHALL be mutually exclusive by construction; an SDA change while SCL is low SHALL be data, not START/STOP.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, and all outputs including sda_oe_out SHALL be 0.
REQ-029 Edge registers SHALL reset to 1 (bus idle) so that release of reset is never detected as an edge.
REQ-030 Reset asserted mid-transfer SHALL abort at once; after release the block SHALL wait for a fresh START.

Configuration
REQ-031 With I2C_CTL_TIMEOUT_EN defined: a 16-bit counter SHALL count cycles with scl_in=0 while not IDLE; at I2C_TIMEOUT_CYCLES the block SHALL go to IDLE, release SDA and pulse timeout_out. Any scl_in=1 SHALL clear the counter.
REQ-032 Without I2C_CTL_TIMEOUT_EN: no counter, and timeout_out SHALL be tied to 0.

Structure
REQ-033 myfilter_pkg SHALL hold I2C_ADDRESS (existing), I2C_TIMEOUT_CYCLES and the state enum i2c_ctl_state_t.
REQ-034 Edge and START/STOP detection SHALL sit in the sub-module i2c_bus_det; the FSM SHALL stay in i2c_ctl.

Verification
REQ-035 Reset, then idle bus -> all outputs 0, busy_out=0.
REQ-036 START, address {I2C_ADDRESS,0}, addrok_in=1 -> 8 next_out pulses, sda_oe_out=1 for ACK clock, clr_out on 9th fall.
REQ-037 Then data 8'hA5 -> sda_bit_out sequence 1,0,1,0,0,1,0,1, byte_valid_out after 8th fall, ACK, STOP -> IDLE.
REQ-038 Address mismatch (addrok_in=0) or R/W=1 -> sda_oe_out stays 0, IGNORE until STOP.
REQ-039 Repeated START after 4 data bits -> clr_out, ADDR, no byte_valid_out.
REQ-040 With I2C_CTL_TIMEOUT_EN, SCL held low I2C_TIMEOUT_CYCLES during DATA_ACK -> timeout_out pulse, sda_oe_out=0, IDLE.
